// File: rtl/nic_ring_node.sv
// -----------------------------------------------------------------------------
// nic_ring_node
//
// Ring-network interface node on a unidirectional, registered packet ring.
// Each cycle the packet arriving from the predecessor is either forwarded
// (age+1), delivered to the local rx FIFO, copied (broadcast), or removed. A
// slot that ends up empty can carry the head of the local tx FIFO. The ring
// path is one register deep.
//
// Packet layout, MSB first:
//   did[IDW] sid[IDW] age[AGEW] ack[1] typ[6] payload[PAYW]
//   typ == 0 marks an empty slot; did == all ones is broadcast.
//
// Ports:
//   rst_i        async active-high reset
//   clk_i        clock
//   id_i         this node's ID (static, never all ones)
//   packet_i     ring input from the predecessor
//   packet_o     registered ring output to the successor
//   tx_packet_i  local packet to send, qualified by tx_valid_i
//   tx_ready_o   tx FIFO has room
//   rx_packet_o  rx FIFO head, qualified by rx_valid_o, popped by rx_ready_i
//   drop_o       one-cycle pulse, aligned with packet_o, per discarded packet
//   stat_*_o     injection / delivery / drop counters
//
// Build option:
//   NIC_RING_STATS_EN  when defined, stat_tx_o/stat_rx_o/stat_drop_o are
//                      32-bit wrapping counters; otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module nic_ring_node #(
    parameter int IDW  = 6,
    parameter int AGEW = 6,
    parameter int PAYW = 72,
    parameter int TXD  = 8,
    parameter int RXD  = 8,
    localparam int PKTW = 2*IDW + AGEW + 7 + PAYW
) (
    input  logic            rst_i,
    input  logic            clk_i,
    input  logic [IDW-1:0]  id_i,
    input  logic [PKTW-1:0] packet_i,
    output logic [PKTW-1:0] packet_o,
    input  logic [PKTW-1:0] tx_packet_i,
    input  logic            tx_valid_i,
    output logic            tx_ready_o,
    output logic [PKTW-1:0] rx_packet_o,
    output logic            rx_valid_o,
    input  logic            rx_ready_i,
    output logic            drop_o,
    output logic [31:0]     stat_tx_o,
    output logic [31:0]     stat_rx_o,
    output logic [31:0]     stat_drop_o
);

    localparam int TXAW = $clog2(TXD);
    localparam int TXCW = TXAW + 1;
    localparam int RXAW = $clog2(RXD);
    localparam int RXCW = RXAW + 1;

    localparam int TYP_LSB = PAYW;
    localparam int AGE_LSB = PAYW + 7;
    localparam int SID_LSB = AGE_LSB + AGEW;
    localparam int DID_LSB = SID_LSB + IDW;

    localparam logic [IDW-1:0]  BCAST   = '1;
    localparam logic [AGEW-1:0] AGE_MAX = '1;
    localparam logic [TXCW-1:0] TX_FULL = TXCW'(TXD);
    localparam logic [RXCW-1:0] RX_FULL = RXCW'(RXD);

    // ring output stage
    logic [PKTW-1:0] packet_q, packet_d;
    logic            drop_q, drop_d;

    // tx FIFO
    logic [PKTW-1:0] tx_mem_q [TXD];
    logic [TXAW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TXAW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TXCW-1:0] tx_cnt_q, tx_cnt_d;

    // rx FIFO
    logic [PKTW-1:0] rx_mem_q [RXD];
    logic [RXAW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RXAW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RXCW-1:0] rx_cnt_q, rx_cnt_d;

    // decoded incoming packet
    logic [IDW-1:0]  in_did, in_sid;
    logic [AGEW-1:0] in_age;
    logic [5:0]      in_typ;

    logic            slot_free, fwd, rx_push, drop, inject;
    logic            tx_push, rx_pop;
    logic [PKTW-1:0] fwd_pkt, inj_pkt;

    assign in_did = packet_i[DID_LSB +: IDW];
    assign in_sid = packet_i[SID_LSB +: IDW];
    assign in_age = packet_i[AGE_LSB +: AGEW];
    assign in_typ = packet_i[TYP_LSB +: 6];

    assign tx_ready_o  = (tx_cnt_q != TX_FULL);
    assign rx_valid_o  = (rx_cnt_q != '0);
    assign rx_packet_o = rx_mem_q[rx_rd_ptr_q];
    assign packet_o    = packet_q;
    assign drop_o      = drop_q;

    assign tx_push = tx_valid_i && tx_ready_o;
    assign rx_pop  = rx_valid_o && rx_ready_i;

    // Slot classification. Exactly one of {free, fwd} holds for any non-NULL
    // packet after the expiry override; rx_push is independent because a
    // broadcast both copies and forwards.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        slot_free = 1'b0;
        fwd       = 1'b0;
        rx_push   = 1'b0;
        drop      = 1'b0;

        if (in_typ == 6'd0) begin
            slot_free = 1'b1;
        end else if (in_sid == id_i && in_did == BCAST) begin
            // own broadcast completed the loop: silently retire it
            slot_free = 1'b1;
        end else if (in_did == id_i) begin
            // full test uses the pre-pop count: a same-cycle pop makes no room
            if (rx_cnt_q != RX_FULL) begin
                rx_push   = 1'b1;
                slot_free = 1'b1;
            end else begin
                fwd = 1'b1;
            end
        end else if (in_did == BCAST) begin
            rx_push = (rx_cnt_q != RX_FULL);
            fwd     = 1'b1;
        end else if (in_sid == id_i) begin
            // unicast nobody claimed came back to us
            drop      = 1'b1;
            slot_free = 1'b1;
        end else begin
            fwd = 1'b1;
        end

        if (fwd && in_age == AGE_MAX) begin
            fwd       = 1'b0;
            drop      = 1'b1;
            slot_free = 1'b1;
        end
    end

    // Output packet selection and injection.
    always_comb begin
        fwd_pkt = packet_i;
        fwd_pkt[AGE_LSB +: AGEW] = in_age + AGEW'(1);

        inj_pkt = tx_mem_q[tx_rd_ptr_q];
        inj_pkt[SID_LSB +: IDW]  = id_i;
        inj_pkt[AGE_LSB +: AGEW] = '0;

        // no pass-through: only an already-queued head can be injected
        inject = slot_free && (tx_cnt_q != '0);

        if (fwd) begin
            packet_d = fwd_pkt;
        end else if (inject) begin
            packet_d = inj_pkt;
        end else begin
            packet_d = '0;
        end
        drop_d = drop;
    end

    // FIFO bookkeeping; pointers wrap naturally at power-of-2 depths.
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + TXAW'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + TXAW'(inject);
        tx_cnt_d    = tx_cnt_q + TXCW'(tx_push) - TXCW'(inject);

        rx_wr_ptr_d = rx_wr_ptr_q + RXAW'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + RXAW'(rx_pop);
        rx_cnt_d    = rx_cnt_q + RXCW'(rx_push) - RXCW'(rx_pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            packet_q    <= '0;
            drop_q      <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            packet_q    <= packet_d;
            drop_q      <= drop_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the counts guard every
    // read, so clearing the arrays would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= tx_packet_i;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= packet_i;
        end
    end

`ifdef NIC_RING_STATS_EN
    logic [31:0] stat_tx_q, stat_tx_d;
    logic [31:0] stat_rx_q, stat_rx_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_tx_d   = stat_tx_q + 32'(inject);
        stat_rx_d   = stat_rx_q + 32'(rx_push);
        stat_drop_d = stat_drop_q + 32'(drop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_tx_q   <= '0;
            stat_rx_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_tx_q   <= stat_tx_d;
            stat_rx_q   <= stat_rx_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_tx_o   = stat_tx_q;
    assign stat_rx_o   = stat_rx_q;
    assign stat_drop_o = stat_drop_q;
`else
    assign stat_tx_o   = '0;
    assign stat_rx_o   = '0;
    assign stat_drop_o = '0;
`endif

endmodule

// File: doc/nic_ring_node.md
Name: nic_ring_node

Overview:
- Parametrised ring-network interface node; next generation of the 32-bit fixed-field NIC packet format.
- Sits between a predecessor and a successor node on a unidirectional registered packet ring.
- Injects locally queued packets into empty ring slots and extracts packets addressed to this node into a receive FIFO.
- Adds broadcast, age-based expiry and returned-packet removal; ID width, age width, payload width and both FIFO depths are generic.

Parameters:
- IDW, 6: width of the did and sid fields; ID of all ones = broadcast.
- AGEW, 6: width of the age field.
- PAYW, 72: payload width (ack/typ excluded).
- TXD, 8: transmit FIFO depth; power of 2, at least 2.
- RXD, 8: receive FIFO depth; power of 2, at least 2.
- PKTW, 2*IDW+AGEW+7+PAYW: packet width; derived, not overridden.

Ports:
- rst_i in 1: asynchronous active-high reset.
- clk_i in 1: clock.
- id_i in IDW: this node's ID; static after reset; must not be all ones.
- packet_i in PKTW: ring input from the predecessor node.
- packet_o out PKTW: registered ring output.
- tx_packet_i in PKTW: local packet to send.
- tx_valid_i in 1: tx_packet_i valid.
- tx_ready_o out 1: tx FIFO not full.
- rx_packet_o out PKTW: head of the rx FIFO.
- rx_valid_o out 1: rx FIFO not empty.
- rx_ready_i in 1: consumer pops the rx head.
- drop_o out 1: one-cycle pulse when a packet is discarded.
- stat_tx_o out 32: packets injected (see optional feature).
- stat_rx_o out 32: packets delivered.
- stat_drop_o out 32: packets dropped.

Behaviour:
- Packet layout, MSB first: did[IDW], sid[IDW], age[AGEW], ack[1], typ[6], payload[PAYW].
- typ==0 is the NULL packet (empty slot).
- Reset: packet_o=0 (NULL); both FIFOs empty; tx_ready_o=1, rx_valid_o=0, drop_o=0, all stats 0.
- Reset mid-operation discards all queued and in-flight packets.
- Ring latency is exactly 1 cycle. Each cycle, evaluate packet_i in priority order:
  1. NULL → slot is free.
  2. sid==id_i and did==BCAST → broadcast has returned to its source; remove it and free the slot; no drop pulse.
  3. did==id_i → if rx FIFO count<RXD, push and free the slot. Otherwise forward with age+1.
  4. did==BCAST (sid≠id_i) → push a copy to the rx FIFO if not full (no copy otherwise) and forward with age+1.
  5. sid==id_i → unclaimed packet has returned to its source; drop, pulse drop_o.
  6. Otherwise forward with age+1.
- Age expiry: any forward whose incoming age equals 2^AGEW-1 becomes a drop (drop_o=1) instead; the slot is freed.
- Injection: if the slot is free and the tx FIFO is non-empty, packet_o takes the tx head with sid overwritten by id_i and age=0, and the tx FIFO pops. A freed slot with nothing to inject outputs 0.
- Injection may use a slot freed in the same cycle by rules 1-3/5/expiry.
- tx FIFO: push when tx_valid_i && tx_ready_o. Simultaneous push and pop is allowed at any count. tx_ready_o = count<TXD, based on the registered count; no pass-through when full.
- rx FIFO: pop when rx_valid_o && rx_ready_i.
  - Full test uses the pre-pop count, so a pop in the same cycle does not make room for a push.
  - rx_packet_o is the registered/array head; it is stable while rx_valid_o && !rx_ready_i.
- Pointers are log2(depth) bits and wrap naturally; counts are log2(depth)+1 bits.
- tx_packet_i typ==0 is accepted and injected as NULL, which wastes no slot.

Optional Feature:
- Macro: NIC_RING_STATS_EN.
- Defined: stat_tx_o, stat_rx_o and stat_drop_o are 32-bit wrapping counters incremented on injection, rx push and drop_o respectively; reset to 0.
- Undefined: all three outputs are constant 0 and no counter flops are generated.

Test Plan:
- Reset, id_i=5, then packet_i did=5 sid=2 typ=1 → rx_valid_o=1 next cycle with an identical packet; packet_o=0.
- tx push did=9 typ=2 age=7 sid=3 while packet_i is NULL → packet_o next cycle has sid=5, age=0, did=9; tx FIFO empties.
- Pass-through packet did=9 sid=2 age=3 → packet_o age=4 after 1 cycle; same packet with age=63 → packet_o=0, drop_o pulses once.
- Fill rx FIFO (8 packets, rx_ready_i=0), send a 9th with did=5 → forwarded with age+1, no push. Pop and push in the same cycle while full → push rejected.
- Broadcast did=63 sid=2 → rx copy plus forward age+1. Broadcast did=63 sid=5 → removed, drop_o=0. Unicast did=9 sid=5 arriving back → drop_o=1.
- With NIC_RING_STATS_EN: after the above sequence, counters match the injection, delivery and drop totals. Without it, all stat outputs read 0.
